// File: rtl/sr_latch_driver.sv
// Command-driven write/read sequencer for a bank of gated SR latches.
// Each write runs setup -> enable pulse -> hold -> verify and reports whether the latch took the value.
module sr_latch_driver #(
    parameter int N_LATCH    = 4,
    parameter int IDX_W      = (N_LATCH > 1) ? $clog2(N_LATCH) : 1,
    parameter int SETUP_CYC  = 1,
    parameter int PULSE_CYC  = 2,
    parameter int VERIFY_CYC = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [IDX_W-1:0]   cmd_idx,
    output logic [N_LATCH-1:0] s,
    output logic [N_LATCH-1:0] r,
    output logic [N_LATCH-1:0] en,
    input  logic [N_LATCH-1:0] q_in,
    output logic               resp_valid,
    output logic [1:0]         resp_err,
    output logic               resp_q,
    output logic               busy
);
    localparam int CNT_W = 16;

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_RST  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    localparam logic [1:0] ERR_OK     = 2'b00;
    localparam logic [1:0] ERR_VERIFY = 2'b01;
    localparam logic [1:0] ERR_OP     = 2'b10;
    localparam logic [1:0] ERR_IDX    = 2'b11;

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, VERIFY, RESP} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [1:0]         op_reg, op_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [1:0]         err_reg, err_next;
    logic [N_LATCH-1:0] s_reg, s_next;
    logic [N_LATCH-1:0] r_reg, r_next;
    logic [N_LATCH-1:0] en_reg, en_next;
    logic               cmd_ready_reg, busy_reg, resp_valid_reg;
    logic [1:0]         resp_err_reg, resp_err_next;
    logic               resp_q_reg, resp_q_next;

    logic [N_LATCH-1:0] sel_cur, sel_next;
    logic               q_sel;
    logic               drive_next;

    genvar gi;
    generate
        for (gi = 0; gi < N_LATCH; gi++) begin : g_sel
            assign sel_cur[gi]  = (idx_reg == IDX_W'(gi));
            assign sel_next[gi] = (idx_next == IDX_W'(gi));
        end
    endgenerate

    assign q_sel = |(q_in & sel_cur);

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        op_next       = op_reg;
        idx_next      = idx_reg;
        err_next      = err_reg;
        resp_err_next = resp_err_reg;
        resp_q_next   = resp_q_reg;

        unique case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    op_next  = cmd_op;
                    idx_next = cmd_idx;
                    cnt_next = '0;
                    err_next = ERR_OK;
                    // Rejected commands pass through a single idle VERIFY cycle so
                    // their response timing matches a one-cycle read.
                    if (cmd_op == OP_ILL) begin
                        err_next   = ERR_OP;
                        cnt_next   = CNT_W'(VERIFY_CYC - 1);
                        state_next = VERIFY;
                    end else if (int'(cmd_idx) >= N_LATCH) begin
                        err_next   = ERR_IDX;
                        cnt_next   = CNT_W'(VERIFY_CYC - 1);
                        state_next = VERIFY;
                    end else if (cmd_op == OP_READ) begin
                        state_next = VERIFY;
                    end else begin
                        state_next = SETUP;
                    end
                end
            end
            SETUP: begin
                if (cnt_reg == CNT_W'(SETUP_CYC - 1)) begin
                    state_next = PULSE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            PULSE: begin
                if (cnt_reg == CNT_W'(PULSE_CYC - 1)) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            HOLD: begin
                state_next = VERIFY;
                cnt_next   = '0;
            end
            VERIFY: begin
                if (cnt_reg == CNT_W'(VERIFY_CYC - 1)) begin
                    state_next = RESP;
                    if (err_reg != ERR_OK) begin
                        resp_err_next = err_reg;
                        resp_q_next   = 1'b0;
                    end else begin
                        resp_q_next   = q_sel;
                        resp_err_next = ERR_OK;
                        if ((op_reg == OP_SET && !q_sel) || (op_reg == OP_RST && q_sel))
                            resp_err_next = ERR_VERIFY;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Only writes ever reach SETUP/PULSE/HOLD, and only one latch bit is ever selected.
        drive_next = (state_next == SETUP) || (state_next == PULSE) || (state_next == HOLD);
        s_next     = (drive_next && op_next == OP_SET) ? sel_next : '0;
        r_next     = (drive_next && op_next == OP_RST) ? sel_next : '0;
        en_next    = (state_next == PULSE) ? sel_next : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            op_reg         <= OP_READ;
            idx_reg        <= '0;
            err_reg        <= ERR_OK;
            s_reg          <= '0;
            r_reg          <= '0;
            en_reg         <= '0;
            cmd_ready_reg  <= 1'b1;
            busy_reg       <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= ERR_OK;
            resp_q_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            op_reg         <= op_next;
            idx_reg        <= idx_next;
            err_reg        <= err_next;
            s_reg          <= s_next;
            r_reg          <= r_next;
            en_reg         <= en_next;
            cmd_ready_reg  <= (state_next == IDLE);
            busy_reg       <= (state_next != IDLE);
            resp_valid_reg <= (state_next == RESP);
            resp_err_reg   <= resp_err_next;
            resp_q_reg     <= resp_q_next;
        end
    end

    assign s          = s_reg;
    assign r          = r_reg;
    assign en         = en_reg;
    assign cmd_ready  = cmd_ready_reg;
    assign busy       = busy_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;
    assign resp_q     = resp_q_reg;

endmodule
